// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared defaults and counter-width helpers for the switch debouncer
package sw_debounce_pkg;

    localparam int SW_WIDTH        = 32;
    localparam int SW_TICK_DIV     = 50000;
    localparam int SW_STABLE_TICKS = 8;

    function automatic int sw_cnt_w(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    typedef logic [$clog2(SW_STABLE_TICKS + 1)-1:0] sw_cnt_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one-bit synchronizer, tick-based stability filter and edge pulses
// Edge pulse flops exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sw_raw_i,
    output logic sw_o,
    output logic sw_rise_o,
    output logic sw_fall_o
);

    localparam int                CNT_W    = sw_cnt_w(STABLE_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (s2 != sw_o) && tick_i && (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            sw_o <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= sw_raw_i;
            s2 <= s1;
            // Any sample agreeing with the accepted level abandons the pending change.
            if (s2 == sw_o) begin
                cnt <= '0;
            end else if (tick_i) begin
                if (accept) begin
                    sw_o <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_rise_o <= 1'b0;
            sw_fall_o <= 1'b0;
        end else begin
            sw_rise_o <= accept & s2;
            sw_fall_o <= accept & ~s2;
        end
    end
`else
    assign sw_rise_o = 1'b0;
    assign sw_fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch bus debouncer: shared tick prescaler plus per-bit filters
// Rise/fall/change pulses are built only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             sw_chg_o
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;

    // With TICK_DIV == 1 the counter sits at 0 and tick stays high.
    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .tick_i    (tick),
            .sw_raw_i  (sw_raw_i[i]),
            .sw_o      (sw_o[i]),
            .sw_rise_o (sw_rise_o[i]),
            .sw_fall_o (sw_fall_o[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    assign sw_chg_o = |(sw_rise_o | sw_fall_o);
`else
    assign sw_chg_o = 1'b0;
`endif

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the raw board switch/key bus before it reaches the core's `io_sw_i` input, where the load/store control unit reads it as a memory-mapped register. Each bit passes through a two-flop synchronizer and a tick-based debounce filter, so software sees only clean, stable levels. Per-bit rise/fall pulses are also produced for future interrupt or polling use.

## Interface
Parameters:
- `WIDTH`, default 32: number of switch bits.
- `TICK_DIV`, default 50000: clocks per debounce tick (1 ms at 50 MHz). Legal range ≥1.
- `STABLE_TICKS`, default 8: number of consecutive mismatching ticks required to accept a new level. Legal range ≥1.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `sw_raw_i`, in, WIDTH: asynchronous raw switch levels.
- `sw_o`, out, WIDTH: debounced levels; connects to core `io_sw_i`.
- `sw_rise_o`, out, WIDTH: one-cycle pulse on a debounced 0→1 change.
- `sw_fall_o`, out, WIDTH: one-cycle pulse on a debounced 1→0 change.
- `sw_chg_o`, out, 1: OR of all rise and fall pulses.

## Operation
- **Synchronizer:** two flops per bit (`s1`, `s2`), both reset to 0.
- **Prescaler:** shared counter `pre`, counting 0..TICK_DIV-1, then wrapping to 0.
  - `tick` is asserted while `pre == TICK_DIV-1`.
  - With TICK_DIV=1, `tick` is asserted every cycle.
- **Per-bit filter:** saturating counter `cnt`, width `$clog2(STABLE_TICKS+1)`. Each clock:
  - `s2 == sw_o[i]`: `cnt <= 0` (a glitch aborts the pending change).
  - `s2 != sw_o[i]` and no `tick`: hold `cnt`.
  - `s2 != sw_o[i]` and `tick`, with `cnt == STABLE_TICKS-1`:
    - `sw_o[i] <= s2`, `cnt <= 0`.
    - Pulse `sw_rise_o[i]` if `s2 == 1`, else pulse `sw_fall_o[i]`.
  - `s2 != sw_o[i]` and `tick`, otherwise: `cnt <= cnt+1`.
- **Pulses:** `sw_rise_o`, `sw_fall_o` and `sw_chg_o` are registered and high for exactly one cycle, in the same cycle that `sw_o` first shows the new value.
- **Independence:** bits filter independently. Simultaneous changes on several bits produce simultaneous pulses, and `sw_chg_o` stays a single one-cycle pulse.
- **Reset:**
  - Values: `sw_o`=0, all pulses 0, `pre`=0, all `cnt`=0, `s1`=`s2`=0.
  - Reset mid-count discards any pending change.
  - After reset, an input held at 1 is re-accepted through the normal filter path and produces a rise pulse.

## Timing
- Synchronizer latency is 2 cycles.
- Acceptance occurs on the STABLE_TICKS-th tick after the mismatch begins at `s2`. From the raw edge, `sw_o` changes after 2+(STABLE_TICKS-1)·TICK_DIV+1 to 2+STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- The bound on the shortest rejected glitch is a pulse shorter than (STABLE_TICKS-1)·TICK_DIV+1 cycles at `s2`; such a pulse is always rejected.
- Throughput: a bit can change at most once per (STABLE_TICKS-1)·TICK_DIV+1 cycles.
- No handshake. Outputs are consumed combinationally by the core every cycle.

## Configuration
- `SW_DEBOUNCE_EDGE_EN`:
  - Defined: edge logic and pulse registers are built as described above.
  - Undefined: `sw_rise_o`, `sw_fall_o` and `sw_chg_o` are tied to 0, no pulse flops are instantiated, and `sw_o` behaviour is unchanged.

## Structure
- **Package `sw_debounce_pkg`** holds:
  - default constants `SW_WIDTH`=32, `SW_TICK_DIV`=50000, `SW_STABLE_TICKS`=8;
  - the `sw_cnt_t` typedef helper for counter width.
- **Sub-module `sw_debounce_bit`**: one synchronizer, counter and edge detector, instantiated WIDTH times in a generate loop.
- **Top level:** the shared prescaler and the `sw_chg_o` OR reduction stay in the top module.

## Test plan
All scenarios use WIDTH=4, TICK_DIV=4, STABLE_TICKS=3 and `SW_DEBOUNCE_EDGE_EN` defined unless noted.
- **Reset values:** hold `rst_i` 3 cycles with `sw_raw_i`=4'hF → `sw_o`=0 and all pulses 0 during reset. Then `sw_o`=4'hF within 11..14 cycles after release, with one `sw_rise_o`=4'hF pulse and one `sw_chg_o` pulse.
- **Clean edge:** `sw_raw_i[0]` 0→1 and held → `sw_o[0]`=1 after 11..14 cycles, `sw_rise_o[0]` high exactly 1 cycle, other bits unchanged.
- **Glitch rejection:** `sw_raw_i[1]` high for 6 cycles, then low → `sw_o[1]` stays 0 and no pulses.
- **Bounce:** `sw_raw_i[2]` toggles every 3 cycles for 30 cycles, then held 1 → exactly one rise pulse, with `sw_o[2]` rising 11..14 cycles after the final edge.
- **Fall and simultaneous events:** bits 0 and 3 fall in the same cycle → one-cycle `sw_fall_o`=4'b1001 and a single `sw_chg_o` pulse. Repeat with the macro undefined → pulses stay 0 and `sw_o` is identical.
- **Reset mid-count:** assert `rst_i` 5 cycles after a raw rise → `sw_o` stays 0. After release, the full 11..14-cycle window restarts.
